// File: rtl/frame_addr_pkg.sv
// Shared types for the frame address sequencer and its serializer clients.
package frame_addr_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_ONE_SHOT = 1'b1
  } seq_mode_e;

  // Sticky status flags, grouped so serializers can pass them around as one field.
  typedef struct packed {
    logic frame_done;
    logic overrun;
    logic underrun;
  } seq_flags_t;

endpackage

// File: rtl/frame_addr_sequencer_addr_wrap_counter.sv
// Modulo-DEPTH address counter with a registered wrap pulse.
module addr_wrap_counter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 62500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;

  // Next address: step by one, folding DEPTH-1 back to 0 with a wrap pulse.
  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (inc) begin
      if (addr_q == LAST) begin
        addr_d = '0;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Pointer and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/frame_addr_sequencer.sv
// Frame-buffer write/read address generator with occupancy and over/underrun tracking.
module frame_addr_sequencer
  import frame_addr_pkg::*;
#(
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned DEPTH  = 62500,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              mode,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LVL_W-1:0]  level,
  output logic              empty,
  output logic              full,
  output logic              wr_wrap,
  output logic              rd_wrap,
  output logic              frame_done,
  output logic              overrun,
  output logic              underrun
);

  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic             restart;
  logic             wr_acc, rd_acc;
  seq_mode_e        mode_e;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  seq_flags_t       flags_q, flags_d;

  assign restart = reset | clear;

  // Accept logic, level update and sticky flags.
  always_comb begin
    mode_e  = seq_mode_e'(mode);
    // A full buffer still takes a write when the same cycle frees a slot.
    wr_acc  = wr_done & ~(full_q & ~rd_done) & ~flags_q.frame_done;
    // Reads see the pre-update level, so no write-through on an empty buffer.
    rd_acc  = rd_done & ~empty_q;
    level_d = level_q;
    flags_d = flags_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_MAX);
    if (wr_done && !wr_acc && !flags_q.frame_done) flags_d.overrun = 1'b1;
    if (rd_done && !rd_acc) flags_d.underrun = 1'b1;
    if (mode_e == MODE_ONE_SHOT) begin
      if (wr_acc && wr_addr == LAST) flags_d.frame_done = 1'b1;
    end else begin
      flags_d.frame_done = 1'b0;
    end
  end

  // Occupancy and flag registers; reset and clear share one restart path.
  always_ff @(posedge clock) begin
    if (restart) begin
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      flags_q <= flags_d;
    end
  end

  addr_wrap_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wr_ptr (
    .clock (clock),
    .reset (restart),
    .inc   (wr_acc),
    .addr  (wr_addr),
    .wrap  (wr_wrap)
  );

  addr_wrap_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_ptr (
    .clock (clock),
    .reset (restart),
    .inc   (rd_acc),
    .addr  (rd_addr),
    .wrap  (rd_wrap)
  );

  assign level      = level_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign frame_done = flags_q.frame_done;
  assign overrun    = flags_q.overrun;
  assign underrun   = flags_q.underrun;

endmodule

// File: tb/tb_frame_addr_sequencer.sv
// Scoreboard bench: a DEPTH=4 instance for corner cases and a default-DEPTH instance for the long run.
module tb_frame_addr_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=4 instance (sel 0)
  logic        s_reset = 1'b0, s_clear = 1'b0, s_mode = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [15:0] s_wr_addr, s_rd_addr;
  logic [2:0]  s_level;
  logic        s_empty, s_full, s_wr_wrap, s_rd_wrap, s_frame_done, s_overrun, s_underrun;

  // Default instance (sel 1)
  logic        b_reset = 1'b0, b_clear = 1'b0, b_mode = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [15:0] b_wr_addr, b_rd_addr;
  logic [15:0] b_level;
  logic        b_empty, b_full, b_wr_wrap, b_rd_wrap, b_frame_done, b_overrun, b_underrun;

  frame_addr_sequencer #(.ADDR_W(16), .DEPTH(4)) dut_small (
    .clock(clock), .reset(s_reset), .clear(s_clear), .mode(s_mode),
    .wr_done(s_wr), .rd_done(s_rd), .wr_addr(s_wr_addr), .rd_addr(s_rd_addr),
    .level(s_level), .empty(s_empty), .full(s_full), .wr_wrap(s_wr_wrap),
    .rd_wrap(s_rd_wrap), .frame_done(s_frame_done), .overrun(s_overrun),
    .underrun(s_underrun)
  );

  frame_addr_sequencer dut_big (
    .clock(clock), .reset(b_reset), .clear(b_clear), .mode(b_mode),
    .wr_done(b_wr), .rd_done(b_rd), .wr_addr(b_wr_addr), .rd_addr(b_rd_addr),
    .level(b_level), .empty(b_empty), .full(b_full), .wr_wrap(b_wr_wrap),
    .rd_wrap(b_rd_wrap), .frame_done(b_frame_done), .overrun(b_overrun),
    .underrun(b_underrun)
  );

  typedef struct {
    int wr_addr, rd_addr, level;
    bit empty, full, wr_wrap, rd_wrap, frame_done, overrun, underrun;
  } obs_t;

  typedef struct {
    int wr, rd, lvl;
    bit frame, ovr, unr, wwrap, rwrap;
  } mdl_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   depth[2] = '{4, 62500};
  mdl_t m[2];
  obs_t sb[$];
  int   big_max_wr = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.wr_addr = int'(s_wr_addr); o.rd_addr = int'(s_rd_addr); o.level = int'(s_level);
      o.empty = s_empty; o.full = s_full; o.wr_wrap = s_wr_wrap; o.rd_wrap = s_rd_wrap;
      o.frame_done = s_frame_done; o.overrun = s_overrun; o.underrun = s_underrun;
    end else begin
      o.wr_addr = int'(b_wr_addr); o.rd_addr = int'(b_rd_addr); o.level = int'(b_level);
      o.empty = b_empty; o.full = b_full; o.wr_wrap = b_wr_wrap; o.rd_wrap = b_rd_wrap;
      o.frame_done = b_frame_done; o.overrun = b_overrun; o.underrun = b_underrun;
    end
    return o;
  endfunction

  // Reference behaviour written from the port-level description.
  task automatic model_step(input int sel, input bit rst, input bit md, input bit wr, input bit rd);
    int  d;
    bit  wa, ra, fl, em;
    d = depth[sel];
    if (rst) begin
      m[sel] = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      return;
    end
    fl = (m[sel].lvl == d);
    em = (m[sel].lvl == 0);
    wa = wr && !(fl && !rd) && !m[sel].frame;
    ra = rd && !em;
    m[sel].wwrap = wa && (m[sel].wr == d - 1);
    m[sel].rwrap = ra && (m[sel].rd == d - 1);
    if (wr && !wa && !m[sel].frame) m[sel].ovr = 1'b1;
    if (rd && !ra) m[sel].unr = 1'b1;
    if (md && wa && m[sel].wr == d - 1) m[sel].frame = 1'b1;
    if (!md) m[sel].frame = 1'b0;
    if (wa) m[sel].wr = (m[sel].wr == d - 1) ? 0 : m[sel].wr + 1;
    if (ra) m[sel].rd = (m[sel].rd == d - 1) ? 0 : m[sel].rd + 1;
    m[sel].lvl = m[sel].lvl + (wa ? 1 : 0) - (ra ? 1 : 0);
  endtask

  task automatic step(input int sel, input string tag, input bit rst, input bit clr,
                      input bit md, input bit wr, input bit rd, input bit chk);
    obs_t e, o;
    @(negedge clock);
    if (sel == 0) begin
      s_reset = rst; s_clear = clr; s_mode = md; s_wr = wr; s_rd = rd;
    end else begin
      b_reset = rst; b_clear = clr; b_mode = md; b_wr = wr; b_rd = rd;
    end
    model_step(sel, rst | clr, md, wr, rd);
    if (chk) begin
      e.wr_addr = m[sel].wr; e.rd_addr = m[sel].rd; e.level = m[sel].lvl;
      e.empty = (m[sel].lvl == 0); e.full = (m[sel].lvl == depth[sel]);
      e.wr_wrap = m[sel].wwrap; e.rd_wrap = m[sel].rwrap;
      e.frame_done = m[sel].frame; e.overrun = m[sel].ovr; e.underrun = m[sel].unr;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    o = sample(sel);
    if (sel == 1 && o.wr_addr > big_max_wr) big_max_wr = o.wr_addr;
    if (chk) begin
      e = sb.pop_front();
      check_eq({tag, ".wr_addr"},    o.wr_addr,    e.wr_addr);
      check_eq({tag, ".rd_addr"},    o.rd_addr,    e.rd_addr);
      check_eq({tag, ".level"},      o.level,      e.level);
      check_eq({tag, ".empty"},      o.empty,      e.empty);
      check_eq({tag, ".full"},       o.full,       e.full);
      check_eq({tag, ".wr_wrap"},    o.wr_wrap,    e.wr_wrap);
      check_eq({tag, ".rd_wrap"},    o.rd_wrap,    e.rd_wrap);
      check_eq({tag, ".frame_done"}, o.frame_done, e.frame_done);
      check_eq({tag, ".overrun"},    o.overrun,    e.overrun);
      check_eq({tag, ".underrun"},   o.underrun,   e.underrun);
    end
  endtask

  initial begin
    obs_t o;
    bit   md, wr, rd, clr;
    int   wr_wraps;

    // Reset state of both instances.
    step(0, "rst_s", 1, 0, 0, 0, 0, 1);
    step(1, "rst_b", 1, 0, 0, 0, 0, 1);
    o = sample(0);
    check_eq("rst_empty_const", o.empty, 1);

    // Three writes, no reads.
    for (int i = 0; i < 3; i++) step(0, "wr3", 0, 0, 0, 1, 0, 1);
    o = sample(0);
    check_eq("wr3_addr_const", o.wr_addr, 3);
    check_eq("wr3_level_const", o.level, 3);

    // Fourth write fills the ring and wraps; fifth overruns.
    wr_wraps = 0;
    step(0, "wr4", 0, 0, 0, 1, 0, 1);
    o = sample(0);
    if (o.wr_wrap) wr_wraps++;
    check_eq("wr4_full_const", o.full, 1);
    step(0, "wr5", 0, 0, 0, 1, 0, 1);
    o = sample(0);
    if (o.wr_wrap) wr_wraps++;
    check_eq("wr_wrap_count", wr_wraps, 1);
    check_eq("wr5_overrun_const", o.overrun, 1);
    check_eq("wr5_addr_const", o.wr_addr, 0);

    // Full with simultaneous write and read.
    step(0, "rst_s2", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, "fill", 0, 0, 0, 1, 0, 1);
    step(0, "full_wr_rd", 0, 0, 0, 1, 1, 1);
    o = sample(0);
    check_eq("full_wr_rd_level_const", o.level, 4);
    check_eq("full_wr_rd_ovr_const", o.overrun, 0);

    // Empty underrun and empty write+read.
    step(0, "rst_s3", 1, 0, 0, 0, 0, 1);
    step(0, "empty_rd", 0, 0, 0, 0, 1, 1);
    step(0, "empty_wr_rd", 0, 0, 0, 1, 1, 1);
    o = sample(0);
    check_eq("empty_wr_rd_level_const", o.level, 1);
    check_eq("empty_wr_rd_rdaddr_const", o.rd_addr, 0);

    // One-shot frame.
    step(0, "rst_s4", 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, "os_wr", 0, 0, 1, 1, 0, 1);
    step(0, "os_wr5", 0, 0, 1, 1, 0, 1);
    o = sample(0);
    check_eq("os_overrun_const", o.overrun, 0);
    for (int i = 0; i < 4; i++) step(0, "os_rd", 0, 0, 1, 0, 1, 1);
    step(0, "os_clear", 0, 1, 1, 0, 0, 1);

    // Random traffic; mode only changes together with clear.
    md = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 24) == 0);
      if (clr) md = $urandom_range(0, 1) != 0;
      wr = $urandom_range(0, 2) != 0;
      rd = $urandom_range(0, 2) != 0;
      step(0, "rand", 0, clr, md, wr, rd, 1);
    end

    // Default depth: prime one word, then write and read together every cycle.
    step(1, "big_wr0", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 62500; i++)
      step(1, "big_run", 0, 0, 0, 1, 1, (i % 5000 == 0) || (i >= 62495));
    check_eq("big_max_wr_addr_le_62499", (big_max_wr <= 62499) ? 1 : 0, 1);
    step(1, "big_rst_wr", 1, 0, 0, 1, 0, 1);
    o = sample(1);
    check_eq("big_rst_wr_addr_const", o.wr_addr, 0);
    check_eq("big_rst_level_const", o.level, 0);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
